mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WORDS_PER_BLOCK, 8, number of 16-bit words per cache block (fixed at 8; 16-byte block).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 icache_req  input  1  I-cache miss fill request; held high until icache_fill_done.
REQ-005 icache_addr  input  16  I-cache missed address; bits [3:0] ignored.
REQ-006 dcache_req  input  1  D-cache miss fill request; held high until dcache_fill_done.
REQ-007 dcache_addr  input  16  D-cache missed or store address.
REQ-008 dcache_wr  input  1  D-cache write-through store request; held high until dcache_wr_ack.
REQ-009 dcache_wr_data  input  16  store data.
REQ-010 mem_enable  output  1  memory access strobe.
REQ-011 mem_wr  output  1  memory write (1) / read (0).
REQ-012 mem_addr  output  16  memory word address.
REQ-013 mem_data_in  output  16  write data to memory.
REQ-014 mem_data_out  input  16  read data from memory.
REQ-015 mem_data_valid  input  1  read data valid, fixed latency after the read strobe.
REQ-016 fill_data  output  16  mem_data_out forwarded to the granted cache.
REQ-017 fill_word  output  3  word index within the block for the current fill_data.
REQ-018 icache_data_valid / dcache_data_valid  output  1 each  fill beat valid for that cache.
REQ-019 icache_fill_done / dcache_fill_done  output  1 each  one-cycle pulse on the final beat.
REQ-020 dcache_wr_ack  output  1  one-cycle pulse when the store is issued.
REQ-021 busy  output  1  high in every state except IDLE.

Function
REQ-022 FSM states: IDLE, WRITE, FILL_I, FILL_D, DONE.
REQ-023 IDLE arbitration priority, fixed: dcache_wr > dcache_req > icache_req; the chosen state and base address {addr[15:4],4'b0} are registered on the next edge.
REQ-024 WRITE lasts one cycle: mem_enable=1, mem_wr=1, mem_addr=dcache_addr (registered), mem_data_in=dcache_wr_data, dcache_wr_ack=1; next state DONE.
REQ-025 FILL_x issue phase: an issue counter runs 0..7 over 8 consecutive cycles; mem_enable=1, mem_wr=0, mem_addr={base[15:4],issue_cnt,1'b0}; after the 8th strobe, mem_enable=0.
REQ-026 FILL_x receive: each mem_data_valid raises the granted cache's data_valid and sets fill_word=recv_cnt; recv_cnt then increments.
REQ-027 On the 8th beat (recv_cnt==7 with valid), fill_done pulses in the same cycle; next state DONE.
REQ-028 DONE lasts one cycle and performs no arbitration, so that the served requester can drop its request; next state IDLE.
REQ-029 mem_data_valid is ignored in IDLE, WRITE and DONE; no cache data_valid is asserted in those states.
REQ-030 A request arriving during a fill is held pending and is served only after DONE; there is no preemption.
REQ-031 Counters are 3-bit and wrap 7->0; both are cleared on entry to FILL_x.
REQ-032 Outputs are zero when not explicitly driven; mem_data_in=0 except in WRITE.

Reset
REQ-033 rst forces IDLE, both counters to 0, and every output to 0 on the next edge, including mid-fill and mid-write.
REQ-034 Memory shares rst, so no in-flight beat survives reset; after reset, requests still held high are re-arbitrated from IDLE.

Structure
REQ-035 Shared package: FSM state encoding, WORDS_PER_BLOCK, BLOCK_OFFSET_BITS=4.
REQ-036 One sub-module, block_word_counter (3-bit, clear, enable, wrap), instantiated twice: issue and receive.

Verification
REQ-037 icache_req=1, icache_addr=16'h1234: mem_addr strobes 16'h1230..16'h123E in 8 cycles; 8 icache_data_valid beats with fill_word 0..7; icache_fill_done on beat 8; busy returns to 0 two cycles later.
REQ-038 icache_req and dcache_req rise in the same cycle: the D fill (addr 16'h8000) is served first; the I fill starts only after DONE; strobes never interleave.
REQ-039 dcache_wr=1, addr 16'h0042, data 16'hBEEF: exactly one cycle with mem_wr=1, mem_addr=16'h0042, mem_data_in=16'hBEEF, and dcache_wr_ack=1.
REQ-040 rst pulsed after the 3rd beat of a fill: all outputs are 0 the next cycle; with req still high, a fresh fill restarts at word 0.
REQ-041 icache_req held high across DONE: no second fill starts until the DONE cycle has passed; a spurious mem_data_valid in IDLE produces no data_valid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the I/D cache fill and store arbiter.
// Block geometry, FSM encoding and the block-base address helper.
package mem_arbiter_pkg;

  localparam int WORDS_PER_BLOCK   = 8;
  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORD_IDX_BITS     = $clog2(WORDS_PER_BLOCK);
  localparam int ADDR_W            = 16;
  localparam int DATA_W            = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_FILL_I = 3'd2,
    ST_FILL_D = 3'd3,
    ST_DONE   = 3'd4
  } arb_state_t;

  // Clears the byte offset so a fill always starts at word 0 of the block.
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'((1 << BLOCK_OFFSET_BITS) - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side request/fill signals and the memory port of the arbiter.
// master = caches plus memory model, slave = the arbiter itself.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                     icache_req;
  logic [ADDR_W-1:0]        icache_addr;
  logic                     dcache_req;
  logic [ADDR_W-1:0]        dcache_addr;
  logic                     dcache_wr;
  logic [DATA_W-1:0]        dcache_wr_data;

  logic                     mem_enable;
  logic                     mem_wr;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data_in;
  logic [DATA_W-1:0]        mem_data_out;
  logic                     mem_data_valid;

  logic [DATA_W-1:0]        fill_data;
  logic [WORD_IDX_BITS-1:0] fill_word;
  logic                     icache_data_valid;
  logic                     dcache_data_valid;
  logic                     icache_fill_done;
  logic                     dcache_fill_done;
  logic                     dcache_wr_ack;
  logic                     busy;

  modport master (
    output icache_req, icache_addr, dcache_req, dcache_addr,
           dcache_wr, dcache_wr_data, mem_data_out, mem_data_valid,
    input  mem_enable, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
           icache_data_valid, dcache_data_valid, icache_fill_done,
           dcache_fill_done, dcache_wr_ack, busy
  );

  modport slave (
    input  icache_req, icache_addr, dcache_req, dcache_addr,
           dcache_wr, dcache_wr_data, mem_data_out, mem_data_valid,
    output mem_enable, mem_wr, mem_addr, mem_data_in, fill_data, fill_word,
           icache_data_valid, dcache_data_valid, icache_fill_done,
           dcache_fill_done, dcache_wr_ack, busy
  );

endinterface

// File: rtl/block_word_counter.sv
// Word index counter within a cache block: synchronous clear, count enable, natural wrap.
// One-cycle update latency; no backpressure, counts whenever enabled.
module block_word_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates D-cache stores and I/D block fills onto one memory port (fixed priority).
// Grant registered one cycle after request; a fill or store runs to DONE before re-arbitration.
module mem_arbiter #(
  parameter int WORDS_PER_BLOCK = mem_arbiter_pkg::WORDS_PER_BLOCK
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  import mem_arbiter_pkg::*;

  localparam logic [WORD_IDX_BITS-1:0] LAST_WORD = WORD_IDX_BITS'(WORDS_PER_BLOCK - 1);

  arb_state_t               state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     issue_done_q, issue_done_d;
  logic                     cnt_clr;
  logic                     issue_en;
  logic                     recv_en;
  logic [WORD_IDX_BITS-1:0] issue_cnt;
  logic [WORD_IDX_BITS-1:0] recv_cnt;

  block_word_counter #(.WIDTH(WORD_IDX_BITS)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt)
  );

  block_word_counter #(.WIDTH(WORD_IDX_BITS)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv_en),
    .cnt (recv_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_done_q <= issue_done_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    addr_d                = addr_q;
    issue_done_d          = 1'b0;
    cnt_clr               = 1'b1;
    issue_en              = 1'b0;
    recv_en               = 1'b0;
    bus.mem_enable        = 1'b0;
    bus.mem_wr            = 1'b0;
    bus.mem_addr          = '0;
    bus.mem_data_in       = '0;
    bus.fill_data         = '0;
    bus.fill_word         = '0;
    bus.icache_data_valid = 1'b0;
    bus.dcache_data_valid = 1'b0;
    bus.icache_fill_done  = 1'b0;
    bus.dcache_fill_done  = 1'b0;
    bus.dcache_wr_ack     = 1'b0;
    bus.busy              = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (bus.dcache_wr) begin
          state_d = ST_WRITE;
          addr_d  = bus.dcache_addr;
        end else if (bus.dcache_req) begin
          state_d = ST_FILL_D;
          addr_d  = block_base(bus.dcache_addr);
        end else if (bus.icache_req) begin
          state_d = ST_FILL_I;
          addr_d  = block_base(bus.icache_addr);
        end
      end

      ST_WRITE: begin
        bus.mem_enable    = 1'b1;
        bus.mem_wr        = 1'b1;
        bus.mem_addr      = addr_q;
        bus.mem_data_in   = bus.dcache_wr_data;
        bus.dcache_wr_ack = 1'b1;
        state_d           = ST_DONE;
      end

      ST_FILL_I, ST_FILL_D: begin
        cnt_clr      = 1'b0;
        issue_done_d = issue_done_q;
        // Read strobes run back to back; returning beats may overlap the tail of the issue phase.
        if (!issue_done_q) begin
          bus.mem_enable = 1'b1;
          bus.mem_addr   = {addr_q[ADDR_W-1:BLOCK_OFFSET_BITS], issue_cnt, 1'b0};
          issue_en       = 1'b1;
          if (issue_cnt == LAST_WORD) begin
            issue_done_d = 1'b1;
          end
        end
        if (bus.mem_data_valid) begin
          recv_en       = 1'b1;
          bus.fill_data = bus.mem_data_out;
          bus.fill_word = recv_cnt;
          if (state_q == ST_FILL_I) begin
            bus.icache_data_valid = 1'b1;
          end else begin
            bus.dcache_data_valid = 1'b1;
          end
          if (recv_cnt == LAST_WORD) begin
            bus.icache_fill_done = (state_q == ST_FILL_I);
            bus.dcache_fill_done = (state_q == ST_FILL_D);
            state_d              = ST_DONE;
          end
        end
      end

      // Gives the served requester a cycle to drop its request before re-arbitration.
      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency read memory model.
// Each scenario task drives stimulus and compares DUT outputs against hand-derived values.
module tb_mem_arbiter;

  localparam logic [15:0] DATA_PAT = 16'h5A5A;

  logic clk;
  logic rst;
  logic spur;
  int   checks;
  int   errors;

  logic        p0, p1;
  logic [15:0] d0, d1;

  mem_arbiter_if bus();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read memory: data = addr ^ DATA_PAT, valid two cycles after the strobe cycle.
  initial begin
    p0 = 1'b0; p1 = 1'b0; d0 = '0; d1 = '0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data_out   = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        p0 = 1'b0; p1 = 1'b0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out   = '0;
      end else if (spur) begin
        p0 = 1'b0; p1 = 1'b0;
        bus.mem_data_valid = 1'b1;
        bus.mem_data_out   = 16'hFFFF;
      end else begin
        bus.mem_data_valid = p1;
        bus.mem_data_out   = p1 ? d1 : 16'h0000;
        p1 = p0;
        d1 = d0;
        p0 = bus.mem_enable && !bus.mem_wr;
        d0 = bus.mem_addr ^ DATA_PAT;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #4;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_enable !== 1'b0 || bus.mem_wr !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b en=%b wr=%b, expected 0 0 0", bus.busy, bus.mem_enable, bus.mem_wr);
    end
    checks++;
    if (bus.mem_addr !== 16'h0 || bus.mem_data_in !== 16'h0 || bus.fill_data !== 16'h0 || bus.fill_word !== 3'd0) begin
      errors++;
      $display("FAIL reset_data: got addr=%h din=%h fdata=%h fword=%0d, expected all 0",
               bus.mem_addr, bus.mem_data_in, bus.fill_data, bus.fill_word);
    end
    checks++;
    if ({bus.icache_data_valid, bus.dcache_data_valid, bus.icache_fill_done, bus.dcache_fill_done, bus.dcache_wr_ack} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.icache_data_valid, bus.dcache_data_valid, bus.icache_fill_done, bus.dcache_fill_done, bus.dcache_wr_ack});
    end
    rst = 1'b0;
    tick;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b, expected 0", bus.busy);
    end
  endtask

  task automatic test_icache_fill;
    logic        exp_en, exp_dv;
    logic [15:0] exp_addr, exp_data;
    bus.icache_addr = 16'h1234;
    bus.icache_req  = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick;
      exp_en   = (c < 8);
      exp_addr = exp_en ? 16'h1230 + 16'(2 * c) : 16'h0000;
      checks++;
      if (bus.mem_enable !== exp_en || bus.mem_addr !== exp_addr || bus.mem_wr !== 1'b0) begin
        errors++;
        $display("FAIL ifill_strobe c=%0d: got en=%b wr=%b addr=%h, expected en=%b wr=0 addr=%h",
                 c, bus.mem_enable, bus.mem_wr, bus.mem_addr, exp_en, exp_addr);
      end
      exp_dv = (c >= 2 && c <= 9);
      checks++;
      if (bus.icache_data_valid !== exp_dv || bus.dcache_data_valid !== 1'b0) begin
        errors++;
        $display("FAIL ifill_valid c=%0d: got i=%b d=%b, expected i=%b d=0",
                 c, bus.icache_data_valid, bus.dcache_data_valid, exp_dv);
      end
      if (exp_dv) begin
        exp_data = (16'h1230 + 16'(2 * (c - 2))) ^ DATA_PAT;
        checks++;
        if (bus.fill_word !== 3'(c - 2) || bus.fill_data !== exp_data) begin
          errors++;
          $display("FAIL ifill_beat c=%0d: got word=%0d data=%h, expected word=%0d data=%h",
                   c, bus.fill_word, bus.fill_data, c - 2, exp_data);
        end
      end
      checks++;
      if (bus.icache_fill_done !== (c == 9) || bus.busy !== (c <= 10)) begin
        errors++;
        $display("FAIL ifill_done_busy c=%0d: got done=%b busy=%b, expected done=%b busy=%b",
                 c, bus.icache_fill_done, bus.busy, (c == 9), (c <= 10));
      end
      if (c == 9) bus.icache_req = 1'b0;
    end
  endtask

  task automatic test_priority;
    logic        is_d, exp_en, beat;
    int          rel;
    logic [15:0] base, exp_addr, exp_data;
    bus.icache_addr = 16'h4446;
    bus.dcache_addr = 16'h8000;
    bus.icache_req  = 1'b1;
    bus.dcache_req  = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick;
      is_d     = (c < 12);
      rel      = is_d ? c : c - 12;
      base     = is_d ? 16'h8000 : 16'h4440;
      exp_en   = (rel < 8);
      exp_addr = exp_en ? base + 16'(2 * rel) : 16'h0000;
      beat     = (rel >= 2 && rel <= 9);
      checks++;
      if (bus.mem_enable !== exp_en || bus.mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL prio_strobe c=%0d: got en=%b addr=%h, expected en=%b addr=%h",
                 c, bus.mem_enable, bus.mem_addr, exp_en, exp_addr);
      end
      checks++;
      if (bus.dcache_data_valid !== (is_d && beat) || bus.icache_data_valid !== (!is_d && beat)) begin
        errors++;
        $display("FAIL prio_valid c=%0d: got d=%b i=%b, expected d=%b i=%b",
                 c, bus.dcache_data_valid, bus.icache_data_valid, is_d && beat, !is_d && beat);
      end
      if (beat) begin
        exp_data = (base + 16'(2 * (rel - 2))) ^ DATA_PAT;
        checks++;
        if (bus.fill_word !== 3'(rel - 2) || bus.fill_data !== exp_data) begin
          errors++;
          $display("FAIL prio_beat c=%0d: got word=%0d data=%h, expected word=%0d data=%h",
                   c, bus.fill_word, bus.fill_data, rel - 2, exp_data);
        end
      end
      checks++;
      if (bus.dcache_fill_done !== (is_d && rel == 9) || bus.icache_fill_done !== (!is_d && rel == 9)
          || bus.busy !== (rel <= 10)) begin
        errors++;
        $display("FAIL prio_done c=%0d: got d=%b i=%b busy=%b, expected d=%b i=%b busy=%b",
                 c, bus.dcache_fill_done, bus.icache_fill_done, bus.busy,
                 is_d && rel == 9, !is_d && rel == 9, rel <= 10);
      end
      if (c == 9)  bus.dcache_req = 1'b0;
      if (c == 21) bus.icache_req = 1'b0;
    end
  endtask

  task automatic test_write;
    int wr_cycles;
    wr_cycles          = 0;
    bus.dcache_addr    = 16'h0042;
    bus.dcache_wr_data = 16'hBEEF;
    bus.dcache_wr      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      if (bus.mem_wr === 1'b1) wr_cycles++;
      if (c == 0) begin
        checks++;
        if (bus.mem_enable !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 16'h0042
            || bus.mem_data_in !== 16'hBEEF || bus.dcache_wr_ack !== 1'b1 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL write_cycle: got en=%b wr=%b addr=%h din=%h ack=%b busy=%b, expected 1 1 0042 beef 1 1",
                   bus.mem_enable, bus.mem_wr, bus.mem_addr, bus.mem_data_in, bus.dcache_wr_ack, bus.busy);
        end
        bus.dcache_wr = 1'b0;
      end else if (c == 1) begin
        checks++;
        if (bus.mem_enable !== 1'b0 || bus.mem_data_in !== 16'h0 || bus.dcache_wr_ack !== 1'b0 || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL write_done: got en=%b din=%h ack=%b busy=%b, expected 0 0000 0 1",
                   bus.mem_enable, bus.mem_data_in, bus.dcache_wr_ack, bus.busy);
        end
      end else if (c == 2) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL write_idle: got busy=%b, expected 0", bus.busy);
        end
      end
    end
    checks++;
    if (wr_cycles !== 1) begin
      errors++;
      $display("FAIL write_count: got %0d write cycles, expected 1", wr_cycles);
    end
    bus.dcache_wr_data = 16'h0000;
  endtask

  task automatic test_reset_mid_fill;
    logic        exp_en, exp_dv;
    logic [15:0] exp_addr, exp_data;
    bus.icache_addr = 16'h2000;
    bus.icache_req  = 1'b1;
    for (int c = 0; c < 5; c++) tick;
    checks++;
    if (bus.icache_data_valid !== 1'b1 || bus.fill_word !== 3'd2) begin
      errors++;
      $display("FAIL rstfill_beat3: got valid=%b word=%0d, expected 1 2", bus.icache_data_valid, bus.fill_word);
    end
    rst = 1'b1;
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_enable !== 1'b0 || bus.mem_addr !== 16'h0
        || bus.icache_data_valid !== 1'b0 || bus.fill_word !== 3'd0 || bus.fill_data !== 16'h0) begin
      errors++;
      $display("FAIL rstfill_outputs: got busy=%b en=%b addr=%h valid=%b word=%0d data=%h, expected all 0",
               bus.busy, bus.mem_enable, bus.mem_addr, bus.icache_data_valid, bus.fill_word, bus.fill_data);
    end
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick;
      exp_en   = (c < 8);
      exp_addr = exp_en ? 16'h2000 + 16'(2 * c) : 16'h0000;
      checks++;
      if (bus.mem_enable !== exp_en || bus.mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL rstfill_strobe c=%0d: got en=%b addr=%h, expected en=%b addr=%h",
                 c, bus.mem_enable, bus.mem_addr, exp_en, exp_addr);
      end
      exp_dv = (c >= 2 && c <= 9);
      checks++;
      if (bus.icache_data_valid !== exp_dv) begin
        errors++;
        $display("FAIL rstfill_valid c=%0d: got %b, expected %b", c, bus.icache_data_valid, exp_dv);
      end
      if (exp_dv) begin
        exp_data = (16'h2000 + 16'(2 * (c - 2))) ^ DATA_PAT;
        checks++;
        if (bus.fill_word !== 3'(c - 2) || bus.fill_data !== exp_data) begin
          errors++;
          $display("FAIL rstfill_beat c=%0d: got word=%0d data=%h, expected word=%0d data=%h",
                   c, bus.fill_word, bus.fill_data, c - 2, exp_data);
        end
      end
      if (c == 9) begin
        checks++;
        if (bus.icache_fill_done !== 1'b1) begin
          errors++;
          $display("FAIL rstfill_done: got %b, expected 1", bus.icache_fill_done);
        end
        bus.icache_req = 1'b0;
      end
    end
  endtask

  task automatic test_hold_across_done;
    logic        exp_en, beat;
    int          rel;
    logic [15:0] exp_addr;
    bus.icache_addr = 16'h0F08;
    bus.icache_req  = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick;
      rel      = (c < 12) ? c : c - 12;
      exp_en   = (rel < 8);
      exp_addr = exp_en ? 16'h0F00 + 16'(2 * rel) : 16'h0000;
      beat     = (rel >= 2 && rel <= 9);
      checks++;
      if (bus.mem_enable !== exp_en || bus.mem_addr !== exp_addr || bus.busy !== (rel <= 10)) begin
        errors++;
        $display("FAIL hold_strobe c=%0d: got en=%b addr=%h busy=%b, expected en=%b addr=%h busy=%b",
                 c, bus.mem_enable, bus.mem_addr, bus.busy, exp_en, exp_addr, rel <= 10);
      end
      checks++;
      if (bus.icache_data_valid !== beat || bus.icache_fill_done !== (rel == 9)) begin
        errors++;
        $display("FAIL hold_valid c=%0d: got valid=%b done=%b, expected valid=%b done=%b",
                 c, bus.icache_data_valid, bus.icache_fill_done, beat, rel == 9);
      end
      if (c == 21) bus.icache_req = 1'b0;
    end
    spur = 1'b1;
    tick;
    checks++;
    if (bus.icache_data_valid !== 1'b0 || bus.dcache_data_valid !== 1'b0 || bus.fill_data !== 16'h0
        || bus.fill_word !== 3'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_valid: got i=%b d=%b data=%h word=%0d busy=%b, expected all 0",
               bus.icache_data_valid, bus.dcache_data_valid, bus.fill_data, bus.fill_word, bus.busy);
    end
    spur = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks             = 0;
    errors             = 0;
    rst                = 1'b1;
    spur               = 1'b0;
    bus.icache_req     = 1'b0;
    bus.icache_addr    = '0;
    bus.dcache_req     = 1'b0;
    bus.dcache_addr    = '0;
    bus.dcache_wr      = 1'b0;
    bus.dcache_wr_data = '0;

    test_reset;
    test_icache_fill;
    test_priority;
    test_write;
    test_reset_mid_fill;
    test_hold_across_done;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
